// File: rtl/clock_monitor.sv
// Purpose: measures period and high time of an asynchronous sig_in in clock cycles, flags in-range and stall.
// Latency: sig_in edge -> 2 sync flops + history flop; meas_valid/period/high_time update 1 cycle after the detected rise.
// Backpressure: none; meas_valid is a one-cycle pulse that must be consumed when it fires.
// Optional feature: define CLK_MON_DUTY_EN to enable high-time (duty) measurement; otherwise high_time reads 0.
module clock_monitor #(
  parameter int CNT_W      = 32,
  parameter int EXP_PERIOD = 200,
  parameter int TOL        = 2,
  parameter int TIMEOUT    = 1000000
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             in_range,
  output logic             stalled
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALLED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ALL_ONES  = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  // Deviation math is one bit wider so |cnt - EXP_PERIOD| never wraps.
  localparam logic [CNT_W:0]   EXP_EXT   = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0]   TOL_EXT   = (CNT_W+1)'(TOL);

  state_t           state;
  state_t           next_state;
  logic             sync1;
  logic             sync2;
  logic             hist;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   cnt_ext;
  logic [CNT_W:0]   diff;
  logic             in_tol;
  logic             arm;
  logic             take;
  logic             cnt_inc;
  logic             stall_set;
  logic             stall_clr;

  // Two-flop synchronizer plus a history flop for edge detection.
  always_ff @(posedge clock) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

  // Tolerance check on the live counter so in_range registers together with period.
  always_comb begin
    cnt_ext = {1'b0, cnt};
    diff    = '0;
    if (cnt_ext >= EXP_EXT) begin
      diff = cnt_ext - EXP_EXT;
    end else begin
      diff = EXP_EXT - cnt_ext;
    end
    in_tol = (diff <= TOL_EXT);
  end

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and datapath controls; a rise always wins over a timeout on the same cycle.
  always_comb begin
    next_state = state;
    arm        = 1'b0;
    take       = 1'b0;
    cnt_inc    = 1'b0;
    stall_set  = 1'b0;
    stall_clr  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state = MEASURE;
          arm        = 1'b1;
        end else if (cnt == TIMEOUT_C) begin
          next_state = STALLED;
          stall_set  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          arm  = 1'b1;
          take = 1'b1;
        end else if (cnt == TIMEOUT_C) begin
          next_state = STALLED;
          stall_set  = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      STALLED: begin
        if (rise) begin
          next_state = MEASURE;
          arm        = 1'b1;
          stall_clr  = 1'b1;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Period counter, measurement outputs and stall flag.
  always_ff @(posedge clock) begin
    if (rst) begin
      cnt        <= '0;
      period     <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      stalled    <= 1'b0;
    end else begin
      meas_valid <= take;
      if (arm) begin
        cnt <= ONE;
      end else if (cnt_inc && (cnt != ALL_ONES)) begin
        cnt <= cnt + ONE;
      end
      if (take) begin
        period   <= cnt;
        in_range <= in_tol;
      end
      if (stall_set) begin
        stalled <= 1'b1;
      end else if (stall_clr) begin
        stalled <= 1'b0;
      end
    end
  end

`ifdef CLK_MON_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hlatch;
  logic             fall;

  assign fall = ~sync2 & hist;

  // High-phase counter, latched on the fall and published with the next measurement.
  always_ff @(posedge clock) begin
    if (rst) begin
      hcnt      <= '0;
      hlatch    <= '0;
      high_time <= '0;
    end else begin
      if (rise) begin
        hcnt <= ONE;
      end else if (sync2 && (hcnt != ALL_ONES)) begin
        hcnt <= hcnt + ONE;
      end
      if (fall) begin
        hlatch <= hcnt;
      end
      if (take) begin
        high_time <= hlatch;
      end
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor with EXP_PERIOD=200, TOL=2, TIMEOUT=1000.
// sig_in is driven 1 ns after each rising clock edge; outputs are sampled at the same point.
// Expected high_time follows the CLK_MON_DUTY_EN build option.
module tb_clock_monitor;

  localparam int CNT_W = 32;

`ifdef CLK_MON_DUTY_EN
  localparam bit DUTY_ON = 1'b1;
`else
  localparam bit DUTY_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             meas_valid;
  logic             in_range;
  logic             stalled;

  int checks = 0;
  int errors = 0;

  clock_monitor #(
    .CNT_W(CNT_W),
    .EXP_PERIOD(200),
    .TOL(2),
    .TIMEOUT(1000)
  ) dut (
    .clock(clock),
    .rst(rst),
    .sig_in(sig_in),
    .period(period),
    .high_time(high_time),
    .meas_valid(meas_valid),
    .in_range(in_range),
    .stalled(stalled)
  );

  always #5 clock = ~clock;

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One sig_in period: h cycles high then l cycles low. The rise of this period is
  // seen by the DUT 3 edges after sig_in goes high, so the measurement of the
  // previous period (or its absence) is checked at c == 2.
  task automatic pulse(input int h, input int l, input bit mv,
                       input int per, input int hi, input bit inr,
                       input bit stl, input string tag);
    int exp_hi;
    exp_hi = DUTY_ON ? hi : 0;
    for (int c = 0; c < h + l; c++) begin
      sig_in = (c < h);
      cycles(1);
      if (c == 2) begin
        chk({tag, ".meas_valid"}, 32'(meas_valid), 32'(mv));
        chk({tag, ".period"}, period, 32'(per));
        chk({tag, ".high_time"}, high_time, 32'(exp_hi));
        chk({tag, ".in_range"}, 32'(in_range), 32'(inr));
        chk({tag, ".stalled"}, 32'(stalled), 32'(stl));
      end else begin
        chk({tag, ".meas_valid_idle"}, 32'(meas_valid), 32'd0);
      end
    end
  endtask

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    cycles(3);
    chk("reset.period", period, 32'd0);
    chk("reset.high_time", high_time, 32'd0);
    chk("reset.meas_valid", 32'(meas_valid), 32'd0);
    chk("reset.in_range", 32'(in_range), 32'd0);
    chk("reset.stalled", 32'(stalled), 32'd0);
    rst = 1'b0;
    cycles(5);

    // 50% divide-by-200: first rise only arms, then steady 200/100 readings.
    pulse(100, 100, 1'b0,   0,   0, 1'b0, 1'b0, "arm");
    pulse(100, 100, 1'b1, 200, 100, 1'b1, 1'b0, "div200_a");
    pulse(100, 100, 1'b1, 200, 100, 1'b1, 1'b0, "div200_b");

    // Periods of 202 then 203: 202 is inside tolerance, 203 is just outside.
    pulse(101, 101, 1'b1, 200, 100, 1'b1, 1'b0, "tol_pre");
    pulse(101, 102, 1'b1, 202, 101, 1'b1, 1'b0, "tol_202");
    pulse(100, 100, 1'b1, 203, 101, 1'b0, 1'b0, "tol_203");

    // Divide-by-3, 1 high / 2 low.
    pulse(1, 2, 1'b1, 200, 100, 1'b1, 1'b0, "div3_pre");
    pulse(1, 2, 1'b1,   3,   1, 1'b0, 1'b0, "div3_a");
    pulse(1, 2, 1'b1,   3,   1, 1'b0, 1'b0, "div3_b");
    pulse(100, 100, 1'b1, 3, 1, 1'b0, 1'b0, "div3_post");
    pulse(100, 100, 1'b1, 200, 100, 1'b1, 1'b0, "relock");

    // Stall: counter is 1 on the 3rd edge after the last rise edge, so it
    // reaches 1000 after edge 1002 and stalled shows after edge 1003.
    cycles(802);
    chk("stall.before", 32'(stalled), 32'd0);
    cycles(1);
    chk("stall.set", 32'(stalled), 32'd1);
    chk("stall.meas_valid", 32'(meas_valid), 32'd0);
    cycles(50);
    chk("stall.hold", 32'(stalled), 32'd1);
    chk("stall.period_hold", period, 32'd200);
    chk("stall.in_range_hold", 32'(in_range), 32'd1);
    pulse(100, 100, 1'b0, 200, 100, 1'b1, 1'b0, "resume_arm");
    pulse(100, 100, 1'b1, 200, 100, 1'b1, 1'b0, "resume_meas");

    // A rise exactly when the counter reaches TIMEOUT is measured, not stalled.
    pulse(100, 900, 1'b1, 200, 100, 1'b1, 1'b0, "edge_pre");
    pulse(100, 100, 1'b1, 1000, 100, 1'b0, 1'b0, "edge_1000");
    pulse(100, 100, 1'b1, 200, 100, 1'b1, 1'b0, "edge_post");

    // Reset mid-period discards everything; the first rise after it only arms.
    sig_in = 1'b1;
    cycles(50);
    rst    = 1'b1;
    sig_in = 1'b0;
    cycles(2);
    chk("midrst.period", period, 32'd0);
    chk("midrst.high_time", high_time, 32'd0);
    chk("midrst.meas_valid", 32'(meas_valid), 32'd0);
    chk("midrst.in_range", 32'(in_range), 32'd0);
    chk("midrst.stalled", 32'(stalled), 32'd0);
    rst = 1'b0;
    cycles(30);
    pulse(100, 100, 1'b0,   0,   0, 1'b0, 1'b0, "postrst_arm");
    pulse(100, 100, 1'b1, 200, 100, 1'b1, 1'b0, "postrst_meas");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
